// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks destination tags through ID/EX, EX/MEM, MEM/WB,
// stalls the front end on load-use hazards and bubbles ID/EX on stalls and branch flushes.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic [4:0]       ID_Rd,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic             ID_Valid,
  input  logic             EX_BranchTaken,
  output logic [4:0]       ID_EXE_Rs,
  output logic [4:0]       ID_EXE_Rt,
  output logic [4:0]       ID_EXE_Rd,
  output logic             ID_EXE_RegWrite,
  output logic             ID_EXE_MemRead,
  output logic [4:0]       EXE_MEM_Rd,
  output logic             EXE_MEM_RegWrite,
  output logic [4:0]       MEM_WB_Rd,
  output logic             MEM_WB_RegWrite,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] stall_count
);

  logic [4:0]       r_ex_rs, r_ex_rt, r_ex_rd;
  logic             r_ex_rw, r_ex_mr;
  logic [4:0]       r_mem_rd;
  logic             r_mem_rw;
  logic [4:0]       r_wb_rd;
  logic             r_wb_rw;
  logic [CNT_W-1:0] r_stall_count;

  logic w_hz, w_stall, w_bubble;

  // A load into r0 never creates a dependency, hence the Rd != 0 term.
  assign w_hz = ID_Valid & r_ex_mr & (r_ex_rd != 5'd0) &
                ((r_ex_rd == IF_ID_Rs) | (IF_ID_UsesRt & (r_ex_rd == IF_ID_Rt)));

  // A taken branch makes the decode instruction wrong-path, so flush overrides stall.
  assign w_stall  = w_hz & ~EX_BranchTaken;
  assign w_bubble = EX_BranchTaken | w_stall | ~ID_Valid;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's value from before this edge, not the freshly updated one.
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex_rs <= 5'd0;
      r_ex_rt <= 5'd0;
      r_ex_rd <= 5'd0;
      r_ex_rw <= 1'b0;
      r_ex_mr <= 1'b0;
    end else begin
      r_ex_rs <= IF_ID_Rs;
      r_ex_rt <= IF_ID_Rt;
      r_ex_rd <= ID_Rd;
      r_ex_rw <= ID_RegWrite;
      r_ex_mr <= ID_MemRead;
    end
  end

  // EX/MEM and MEM/WB never stall or flush: the instruction in EX on a taken branch is the branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_rd <= 5'd0;
      r_mem_rw <= 1'b0;
      r_wb_rd  <= 5'd0;
      r_wb_rw  <= 1'b0;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign ID_EXE_Rs        = r_ex_rs;
  assign ID_EXE_Rt        = r_ex_rt;
  assign ID_EXE_Rd        = r_ex_rd;
  assign ID_EXE_RegWrite  = r_ex_rw;
  assign ID_EXE_MemRead   = r_ex_mr;
  assign EXE_MEM_Rd       = r_mem_rd;
  assign EXE_MEM_RegWrite = r_mem_rw;
  assign MEM_WB_Rd        = r_wb_rd;
  assign MEM_WB_RegWrite  = r_wb_rw;
  assign PCWrite          = ~w_stall;
  assign IF_ID_Write      = ~w_stall;
  assign IF_ID_Flush      = EX_BranchTaken;
  assign stall_count      = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push hand-computed
// expected outputs; a negedge monitor pops and compares. A CNT_W=2 twin checks saturation.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  if_rs, if_rt, id_rd;
  logic        uses_rt, id_rw, id_mr, id_v, br;

  logic [4:0]  ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        ex_rw, ex_mr, mem_rw, wb_rw, pcw, ifw, flush;
  logic [15:0] cnt;

  logic [4:0]  ex_rs_b, ex_rt_b, ex_rd_b, mem_rd_b, wb_rd_b;
  logic        ex_rw_b, ex_mr_b, mem_rw_b, wb_rw_b, pcw_b, ifw_b, flush_b;
  logic [1:0]  cnt_b;

  outs_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .IF_ID_UsesRt(uses_rt),
    .ID_Rd(id_rd), .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_Valid(id_v),
    .EX_BranchTaken(br),
    .ID_EXE_Rs(ex_rs), .ID_EXE_Rt(ex_rt), .ID_EXE_Rd(ex_rd),
    .ID_EXE_RegWrite(ex_rw), .ID_EXE_MemRead(ex_mr),
    .EXE_MEM_Rd(mem_rd), .EXE_MEM_RegWrite(mem_rw),
    .MEM_WB_Rd(wb_rd), .MEM_WB_RegWrite(wb_rw),
    .PCWrite(pcw), .IF_ID_Write(ifw), .IF_ID_Flush(flush),
    .stall_count(cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .IF_ID_UsesRt(uses_rt),
    .ID_Rd(id_rd), .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_Valid(id_v),
    .EX_BranchTaken(br),
    .ID_EXE_Rs(ex_rs_b), .ID_EXE_Rt(ex_rt_b), .ID_EXE_Rd(ex_rd_b),
    .ID_EXE_RegWrite(ex_rw_b), .ID_EXE_MemRead(ex_mr_b),
    .EXE_MEM_Rd(mem_rd_b), .EXE_MEM_RegWrite(mem_rw_b),
    .MEM_WB_Rd(wb_rd_b), .MEM_WB_RegWrite(wb_rw_b),
    .PCWrite(pcw_b), .IF_ID_Write(ifw_b), .IF_ID_Flush(flush_b),
    .stall_count(cnt_b)
  );

  task automatic check(input outs_t act, input outs_t exp, input int idx);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d: got ex=%0d/%0d/%0d rw%0b mr%0b mem=%0d/%0b wb=%0d/%0b pcw%0b ifw%0b fl%0b cnt=%0d cnt2=%0d, want ex=%0d/%0d/%0d rw%0b mr%0b mem=%0d/%0b wb=%0d/%0b pcw%0b ifw%0b fl%0b cnt=%0d cnt2=%0d",
               idx, act.ex_rs, act.ex_rt, act.ex_rd, act.ex_rw, act.ex_mr, act.mem_rd, act.mem_rw,
               act.wb_rd, act.wb_rw, act.pcw, act.ifw, act.flush, act.cnt, act.cnt2,
               exp.ex_rs, exp.ex_rt, exp.ex_rd, exp.ex_rw, exp.ex_mr, exp.mem_rd, exp.mem_rw,
               exp.wb_rd, exp.wb_rw, exp.pcw, exp.ifw, exp.flush, exp.cnt, exp.cnt2);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    int idx = 0;
    outs_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        act = '{ex_rs, ex_rt, ex_rd, ex_rw, ex_mr, mem_rd, mem_rw, wb_rd, wb_rw,
                pcw, ifw, flush, cnt, cnt_b};
        // The twin must track the main DUT on everything except the counter width.
        if ({ex_rs_b, ex_rt_b, ex_rd_b, ex_rw_b, ex_mr_b, mem_rd_b, mem_rw_b, wb_rd_b,
             wb_rw_b, pcw_b, ifw_b, flush_b} !==
            {ex_rs, ex_rt, ex_rd, ex_rw, ex_mr, mem_rd, mem_rw, wb_rd, wb_rw, pcw, ifw, flush})
          act.cnt2 = 2'bxx;
        check(act, exp_q.pop_front(), idx);
        idx++;
      end
    end
  end

  // One cycle of stimulus plus the expected outputs visible during that cycle.
  task automatic row(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic v,
                     input logic b,
                     input logic [4:0] e_rs, input logic [4:0] e_rt, input logic [4:0] e_rd,
                     input logic e_rw, input logic e_mr, input logic [4:0] m_rd,
                     input logic m_rw, input logic [4:0] w_rd, input logic w_rw,
                     input logic e_pcw, input logic e_fl, input int e_cnt, input int e_cnt2);
    outs_t e;
    @(posedge clk);
    #1;
    rst = r; if_rs = rs; if_rt = rt; uses_rt = ut; id_rd = rd;
    id_rw = rw; id_mr = mr; id_v = v; br = b;
    e = '{e_rs, e_rt, e_rd, e_rw, e_mr, m_rd, m_rw, w_rd, w_rw,
          e_pcw, e_pcw, e_fl, 16'(e_cnt), 2'(e_cnt2)};
    exp_q.push_back(e);
  endtask

  task automatic rst_row();
    outs_t e;
    @(posedge clk);
    #1;
    rst = 1'b1; if_rs = 5'($urandom); if_rt = 5'($urandom); uses_rt = 1'($urandom);
    id_rd = 5'($urandom); id_rw = 1'($urandom); id_mr = 1'($urandom);
    id_v = 1'($urandom); br = 1'b0;
    e = '0;
    e.pcw = 1'b1;
    e.ifw = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; if_rs = 5'd0; if_rt = 5'd0; uses_rt = 1'b0; id_rd = 5'd0;
    id_rw = 1'b0; id_mr = 1'b0; id_v = 1'b0; br = 1'b0;

    rst_row();
    rst_row();
    //   r rs rt ut rd rw mr v br | ex_rs rt rd rw mr | mem rd rw | wb rd rw | pcw fl cnt cnt2
    // Load-use on Rs: stall one cycle, bubble, then consumer enters EX.
    row(0, 1, 2, 1, 5, 1, 1, 1, 0,   0, 0, 0, 0, 0,   0, 0,   0, 0,   1, 0, 0, 0);
    row(0, 5, 3, 1, 6, 1, 0, 1, 0,   1, 2, 5, 1, 1,   0, 0,   0, 0,   0, 0, 0, 0);
    row(0, 5, 3, 1, 6, 1, 0, 1, 0,   0, 0, 0, 0, 0,   5, 1,   0, 0,   1, 0, 1, 1);
    // Load to r0 then reader of r0: no stall.
    row(0, 0, 0, 0, 0, 1, 1, 1, 0,   5, 3, 6, 1, 0,   0, 0,   5, 1,   1, 0, 1, 1);
    row(0, 0, 0, 1, 8, 1, 0, 1, 0,   0, 0, 0, 1, 1,   6, 1,   0, 0,   1, 0, 1, 1);
    // Load to r7 then Rt=7 with UsesRt=0: no stall.
    row(0, 4, 4, 1, 7, 1, 1, 1, 0,   0, 0, 8, 1, 0,   0, 1,   6, 1,   1, 0, 1, 1);
    row(0, 2, 7, 0, 9, 1, 0, 1, 0,   4, 4, 7, 1, 1,   8, 1,   0, 1,   1, 0, 1, 1);
    // Flush beats stall.
    row(0, 1, 1, 0, 9, 1, 1, 1, 0,   2, 7, 9, 1, 0,   7, 1,   8, 1,   1, 0, 1, 1);
    row(0, 9, 0, 1, 10, 1, 0, 1, 1,  1, 1, 9, 1, 1,   9, 1,   7, 1,   1, 1, 1, 1);
    // Tag propagation of an ALU op with Rd=12, then invalid slots.
    row(0, 3, 4, 1, 12, 1, 0, 1, 0,  0, 0, 0, 0, 0,   9, 1,   9, 1,   1, 0, 1, 1);
    row(0, 12, 12, 1, 13, 1, 1, 0, 0, 3, 4, 12, 1, 0, 0, 0,   9, 1,   1, 0, 1, 1);
    row(0, 12, 12, 1, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0,  12, 1,  0, 0,   1, 0, 1, 1);
    row(0, 12, 12, 1, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0,   12, 1,  1, 0, 1, 1);
    // Chain of dependent loads: one stall per pair, counters climb to 5 / saturate at 3.
    row(0, 1, 1, 0, 5, 1, 1, 1, 0,   0, 0, 0, 0, 0,   0, 0,   0, 0,   1, 0, 1, 1);
    row(0, 5, 0, 0, 6, 1, 1, 1, 0,   1, 1, 5, 1, 1,   0, 0,   0, 0,   0, 0, 1, 1);
    row(0, 5, 0, 0, 6, 1, 1, 1, 0,   0, 0, 0, 0, 0,   5, 1,   0, 0,   1, 0, 2, 2);
    row(0, 6, 0, 0, 7, 1, 1, 1, 0,   5, 0, 6, 1, 1,   0, 0,   5, 1,   0, 0, 2, 2);
    row(0, 6, 0, 0, 7, 1, 1, 1, 0,   0, 0, 0, 0, 0,   6, 1,   0, 0,   1, 0, 3, 3);
    row(0, 0, 7, 1, 8, 1, 1, 1, 0,   6, 0, 7, 1, 1,   0, 0,   6, 1,   0, 0, 3, 3);
    row(0, 0, 7, 1, 8, 1, 1, 1, 0,   0, 0, 0, 0, 0,   7, 1,   0, 0,   1, 0, 4, 3);
    row(0, 8, 0, 0, 9, 1, 1, 1, 0,   0, 7, 8, 1, 1,   0, 0,   7, 1,   0, 0, 4, 3);
    row(0, 8, 0, 0, 9, 1, 1, 1, 0,   0, 0, 0, 0, 0,   8, 1,   0, 0,   1, 0, 5, 3);
    // Reset while stalling: comb stall still visible, then pipeline and counters clear.
    row(1, 9, 0, 0, 10, 1, 1, 1, 0,  8, 0, 9, 1, 1,   0, 0,   8, 1,   0, 0, 5, 3);
    row(0, 9, 0, 0, 10, 1, 1, 1, 0,  0, 0, 0, 0, 0,   0, 0,   0, 0,   1, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0,   9, 0, 10, 1, 1,  0, 0,   0, 0,   1, 0, 0, 0);

    repeat (10) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block that produces the register-tag and write-enable fields consumed by the forwarding logic: ID_EXE_Rs/Rt, EXE_MEM_Rd/RegWrite and MEM_WB_Rd/RegWrite. It tracks destination tags through the ID/EX, EX/MEM and MEM/WB stages. It detects load-use hazards that forwarding cannot cover, stalls the front end, inserts bubbles, and applies branch flushes. It sits beside the decode stage and feeds both the forwarding unit and the PC / IF_ID write enables.

## Interface
- CNT_W, 16, width of the saturating stall-event counter.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- IF_ID_Rs  in  5  source register 1 of the instruction in decode.
- IF_ID_Rt  in  5  source register 2 of the instruction in decode.
- IF_ID_UsesRt  in  1  decode instruction actually reads Rt.
- ID_Rd  in  5  destination of the decode instruction, already muxed (rt/rd/31).
- ID_RegWrite  in  1  decode instruction writes a register.
- ID_MemRead  in  1  decode instruction is a load.
- ID_Valid  in  1  decode slot holds a real instruction.
- EX_BranchTaken  in  1  branch or jump resolved taken in EX this cycle.
- ID_EXE_Rs, ID_EXE_Rt  out  5 each  EX-stage source tags.
- ID_EXE_Rd  out  5  EX-stage destination.
- ID_EXE_RegWrite, ID_EXE_MemRead  out  1 each.
- EXE_MEM_Rd  out  5;  EXE_MEM_RegWrite  out  1.
- MEM_WB_Rd  out  5;  MEM_WB_RegWrite  out  1.
- PCWrite  out  1  PC may advance.
- IF_ID_Write  out  1  IF/ID register may load.
- IF_ID_Flush  out  1  IF/ID register must load a NOP.
- stall_count  out  CNT_W  number of load-use stall cycles, saturating.

## Operation
- Hazard is combinational:
  - `hz = ID_Valid & ID_EXE_MemRead & (ID_EXE_Rd != 0) & ((ID_EXE_Rd == IF_ID_Rs) | (IF_ID_UsesRt & (ID_EXE_Rd == IF_ID_Rt)))`.
  - Rd = 0 never causes a hazard.
- Stall control:
  - `stall = hz & ~EX_BranchTaken`.
  - PCWrite = IF_ID_Write = ~stall.
  - IF_ID_Flush = EX_BranchTaken.
- ID/EX load, on each edge, in priority order:
  1. rst → bubble.
  2. EX_BranchTaken → bubble. The decode instruction is wrong-path; flush wins over stall.
  3. stall → bubble.
  4. ID_Valid = 0 → bubble.
  5. Otherwise load {IF_ID_Rs, IF_ID_Rt, ID_Rd, ID_RegWrite, ID_MemRead}.
- Bubble = all tags 0, RegWrite 0, MemRead 0.
- EX/MEM loads {ID_EXE_Rd, ID_EXE_RegWrite} every cycle. It never stalls and is never flushed, because the instruction in EX on a taken branch is the branch itself.
- MEM/WB loads {EXE_MEM_Rd, EXE_MEM_RegWrite} every cycle.
- stall_count increments by 1 on each edge where stall = 1. It holds at 2^CNT_W − 1 and does not wrap.
- Reset values:
  - All stage registers are 0; stall_count is 0.
  - Outputs therefore read: all tags and RegWrite/MemRead 0, PCWrite 1, IF_ID_Write 1, IF_ID_Flush 0.
  - If a combinational input asserts during reset, PCWrite, IF_ID_Write and IF_ID_Flush follow the rules above.
- Reset mid-stall: the pipeline is cleared. Next cycle ID_EXE_MemRead = 0, so no stall.

## Timing
- Stage tag latency: the decode fields appear on ID_EXE_* one edge later, on EXE_MEM_* two edges later, and on MEM_WB_* three edges later.
- A load-use stall lasts exactly one cycle:
  - The load moves to EX/MEM on the next edge.
  - ID_EXE_MemRead becomes 0, so `hz` drops.
  - The held consumer enters ID/EX on the following edge.
- Back-to-back loads feeding each other give one stall per pair, never two in a row for the same consumer.
- stall, PCWrite, IF_ID_Write and IF_ID_Flush are same-cycle combinational from inputs and registered state. There is no registered output delay.
- EX_BranchTaken and hz in the same cycle: stall = 0, IF_ID_Flush = 1, ID/EX gets a bubble, and stall_count does not increment.

## Test plan
- Reset and defaults:
  - Stimulus: assert rst for 2 cycles with random inputs.
  - Required: all tags and enables 0, PCWrite = 1, IF_ID_Write = 1, stall_count = 0.
- Load-use on Rs:
  - Stimulus: load with ID_Rd = 5, ID_MemRead = 1; next cycle decode IF_ID_Rs = 5.
  - Required: stall = 1 for exactly 1 cycle and ID/EX gets a bubble (ID_EXE_Rd = 0).
  - Required: the consumer appears with ID_EXE_Rs = 5 one cycle later; stall_count = 1.
- No false stall:
  - Stimulus: load to Rd = 0 followed by a reader of r0.
  - Required: no stall.
  - Stimulus: load to r7, then IF_ID_Rt = 7 with IF_ID_UsesRt = 0.
  - Required: no stall.
- Flush beats stall:
  - Stimulus: load Rd = 9 in EX, decode reads r9, EX_BranchTaken = 1 in the same cycle.
  - Required: PCWrite = 1, IF_ID_Flush = 1, ID/EX bubble, stall_count unchanged.
- Tag propagation:
  - Stimulus: ALU op with Rd = 12, RegWrite = 1.
  - Required: EXE_MEM_Rd = 12 with RegWrite = 1 after 2 edges; MEM_WB_Rd = 12 with RegWrite = 1 after 3 edges.
- Counter saturation and reset mid-stall:
  - Stimulus: CNT_W = 2, force 5 stall cycles.
  - Required: stall_count = 3.
  - Stimulus: assert rst while stall = 1.
  - Required: next cycle stall = 0 and stall_count = 0.
